// File: rtl/queue_wait_engine.sv
// Queue occupancy counter with synchronised button/teller inputs and a
// sequential restoring divider that estimates customer waiting time.
module queue_wait_engine #(
   parameter int MAX_COUNT = 7,
   parameter int N_TELLERS = 3,
   parameter int SVC_TIME  = 5,
   parameter int CNT_W     = $clog2(MAX_COUNT+1),
   parameter int WAIT_W    = CNT_W + $clog2(SVC_TIME+1) + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           arrive_btn,
   input  logic                           depart_btn,
   input  logic [N_TELLERS-1:0]           teller_en,
   output logic [CNT_W-1:0]               count,
   output logic                           empty,
   output logic                           full,
   output logic                           reject_full,
   output logic                           reject_empty,
   output logic [$clog2(N_TELLERS+1)-1:0] active_tellers,
   output logic                           no_teller,
   output logic [WAIT_W-1:0]              wait_time,
   output logic                           wait_valid
);

   localparam int AT_W = $clog2(N_TELLERS+1);
   localparam int BC_W = $clog2(WAIT_W+1);
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_COUNT);

   if (MAX_COUNT*SVC_TIME + N_TELLERS - 1 >= (1 << WAIT_W)) begin : g_num_chk
      $error("queue_wait_engine: numerator does not fit WAIT_W");
   end

   typedef enum logic {IDLE, CALC} state_t;

   // bit 0 = arrive, bit 1 = depart
   logic [1:0]           btn_s1_d, btn_s1_q, btn_s2_d, btn_s2_q, btn_prev_d, btn_prev_q;
   logic [N_TELLERS-1:0] ten_s1_d, ten_s1_q, ten_s2_d, ten_s2_q;
   logic [CNT_W-1:0]     count_d, count_q;
   logic                 empty_d, empty_q, full_d, full_q;
   logic                 rej_full_d, rej_full_q, rej_empty_d, rej_empty_q;
   logic                 arr_ev, dep_ev;
   logic [AT_W-1:0]      at_c;

   state_t               state_d, state_q;
   logic [CNT_W-1:0]     lat_cnt_d, lat_cnt_q;
   logic [AT_W-1:0]      lat_at_d, lat_at_q;
   logic [WAIT_W-1:0]    num_d, num_q;
   logic [WAIT_W:0]      rem_d, rem_q, rem_sh;
   logic [BC_W-1:0]      bit_cnt_d, bit_cnt_q;
   logic [WAIT_W-1:0]    wait_time_d, wait_time_q;
   logic                 no_teller_d, no_teller_q, wait_valid_d, wait_valid_q;
   logic                 op_chg, q_bit;

   always_comb begin
      btn_s1_d   = {depart_btn, arrive_btn};
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_s2_q;
      ten_s1_d   = teller_en;
      ten_s2_d   = ten_s1_q;
   end

   always_comb begin
      at_c = '0;
      for (int i = 0; i < N_TELLERS; i++) at_c = at_c + AT_W'(ten_s2_q[i]);
   end

   // Simultaneous arrive and depart cancel out, so neither rejects.
   always_comb begin
      arr_ev      = btn_s2_q[0] & ~btn_prev_q[0];
      dep_ev      = btn_s2_q[1] & ~btn_prev_q[1];
      count_d     = count_q;
      rej_full_d  = 1'b0;
      rej_empty_d = 1'b0;
      if (arr_ev && !dep_ev) begin
         if (count_q == MAXC) rej_full_d = 1'b1;
         else                 count_d    = count_q + 1'b1;
      end else if (dep_ev && !arr_ev) begin
         if (count_q == '0) rej_empty_d = 1'b1;
         else               count_d     = count_q - 1'b1;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == MAXC);
   end

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      lat_at_d     = lat_at_q;
      num_d        = num_q;
      rem_d        = rem_q;
      bit_cnt_d    = bit_cnt_q;
      wait_time_d  = wait_time_q;
      no_teller_d  = no_teller_q;
      wait_valid_d = wait_valid_q;
      op_chg       = (count_q != lat_cnt_q) || (at_c != lat_at_q);
      rem_sh       = {rem_q[WAIT_W-1:0], num_q[WAIT_W-1]};
      q_bit        = (rem_sh >= (WAIT_W+1)'(lat_at_q));
      // A changed operand always (re)starts the division, aborting any
      // calculation in flight.
      if (op_chg) begin
         lat_cnt_d    = count_q;
         lat_at_d     = at_c;
         num_d        = WAIT_W'(count_q) * WAIT_W'(SVC_TIME) + WAIT_W'(at_c) - WAIT_W'(1);
         rem_d        = '0;
         bit_cnt_d    = '0;
         wait_valid_d = 1'b0;
         state_d      = CALC;
      end else if (state_q == CALC) begin
         rem_d     = q_bit ? rem_sh - (WAIT_W+1)'(lat_at_q) : rem_sh;
         num_d     = {num_q[WAIT_W-2:0], q_bit};
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (bit_cnt_q == BC_W'(WAIT_W-1)) begin
            wait_time_d  = (lat_at_q == '0 || lat_cnt_q == '0) ? '0 : num_d;
            no_teller_d  = (lat_at_q == '0);
            wait_valid_d = 1'b1;
            state_d      = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_s1_q     <= '0;
         btn_s2_q     <= '0;
         btn_prev_q   <= '0;
         ten_s1_q     <= '0;
         ten_s2_q     <= '0;
         count_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         rej_full_q   <= 1'b0;
         rej_empty_q  <= 1'b0;
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         lat_at_q     <= '0;
         num_q        <= '0;
         rem_q        <= '0;
         bit_cnt_q    <= '0;
         wait_time_q  <= '0;
         no_teller_q  <= 1'b1;
         wait_valid_q <= 1'b1;
      end else begin
         btn_s1_q     <= btn_s1_d;
         btn_s2_q     <= btn_s2_d;
         btn_prev_q   <= btn_prev_d;
         ten_s1_q     <= ten_s1_d;
         ten_s2_q     <= ten_s2_d;
         count_q      <= count_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         rej_full_q   <= rej_full_d;
         rej_empty_q  <= rej_empty_d;
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         lat_at_q     <= lat_at_d;
         num_q        <= num_d;
         rem_q        <= rem_d;
         bit_cnt_q    <= bit_cnt_d;
         wait_time_q  <= wait_time_d;
         no_teller_q  <= no_teller_d;
         wait_valid_q <= wait_valid_d;
      end
   end

   assign count          = count_q;
   assign empty          = empty_q;
   assign full           = full_q;
   assign reject_full    = rej_full_q;
   assign reject_empty   = rej_empty_q;
   assign active_tellers = at_c;
   assign no_teller      = no_teller_q;
   assign wait_time      = wait_time_q;
   assign wait_valid     = wait_valid_q;

endmodule

// File: tb/tb_queue_wait_engine.sv
// Directed bench for queue_wait_engine with default parameters
// (MAX_COUNT=7, N_TELLERS=3, SVC_TIME=5, WAIT_W=7).
module tb_queue_wait_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       arrive_btn, depart_btn;
   logic [2:0] teller_en;
   logic [2:0] count;
   logic       empty, full, reject_full, reject_empty, no_teller, wait_valid;
   logic [1:0] active_tellers;
   logic [6:0] wait_time;

   int checks   = 0;
   int failures = 0;

   queue_wait_engine dut (
      .clk(clk), .reset(reset), .arrive_btn(arrive_btn), .depart_btn(depart_btn),
      .teller_en(teller_en), .count(count), .empty(empty), .full(full),
      .reject_full(reject_full), .reject_empty(reject_empty),
      .active_tellers(active_tellers), .no_teller(no_teller),
      .wait_time(wait_time), .wait_valid(wait_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Button event lands on count three edges after it is driven.
   task automatic press(input logic a, input logic d);
      arrive_btn = a; depart_btn = d;
      tick(3);
      arrive_btn = 1'b0; depart_btn = 1'b0;
      tick(2);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!wait_valid && n < 40) begin
         tick(1);
         n++;
      end
      chk(tag, wait_valid, 1);
   endtask

   initial begin
      reset = 1'b1; arrive_btn = 1'b0; depart_btn = 1'b0; teller_en = 3'b000;
      tick(3);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rejects", {reject_full, reject_empty}, 0);
      chk("rst_wait", wait_time, 0);
      chk("rst_no_teller", no_teller, 1);
      chk("rst_valid", wait_valid, 1);
      chk("rst_active", active_tellers, 0);

      reset = 1'b0;
      teller_en = 3'b011;
      tick(3);
      chk("active_2", active_tellers, 2);
      wait_done("wv_t2");
      chk("wait_c0", wait_time, 0);
      chk("no_teller_t2", no_teller, 0);

      // first arrive: exact latency
      arrive_btn = 1'b1;
      tick(2);
      chk("lat_before", count, 0);
      tick(1);
      chk("count_1", count, 1);
      chk("empty_c1", empty, 0);
      arrive_btn = 1'b0;
      tick(2);
      wait_done("wv_c1");
      chk("wait_c1", wait_time, 3);

      // second arrive held high: one event, wait latency of WAIT_W+1
      arrive_btn = 1'b1;
      tick(3);
      chk("count_2", count, 2);
      tick(1);
      chk("wv_fall", wait_valid, 0);
      tick(6);
      chk("wv_early", wait_valid, 0);
      tick(1);
      chk("wv_rise", wait_valid, 1);
      chk("wait_c2_t2", wait_time, 5);
      chk("held_once", count, 2);
      arrive_btn = 1'b0;
      tick(2);

      for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
      chk("count_7", count, 7);
      chk("full_7", full, 1);
      arrive_btn = 1'b1;
      tick(3);
      chk("rej_full_hi", reject_full, 1);
      chk("count_held7", count, 7);
      tick(1);
      chk("rej_full_lo", reject_full, 0);
      arrive_btn = 1'b0;
      tick(2);
      wait_done("wv_c7");
      chk("wait_c7_t2", wait_time, 18);

      for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
      chk("count_3", count, 3);
      chk("full_3", full, 0);
      arrive_btn = 1'b1; depart_btn = 1'b1;
      tick(3);
      chk("both_c3_cnt", count, 3);
      chk("both_c3_rej", {reject_full, reject_empty}, 0);
      tick(1);
      chk("both_c3_rej2", {reject_full, reject_empty}, 0);
      arrive_btn = 1'b0; depart_btn = 1'b0;
      tick(2);

      for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
      chk("count_0", count, 0);
      chk("empty_0", empty, 1);
      depart_btn = 1'b1;
      tick(3);
      chk("rej_empty_hi", reject_empty, 1);
      chk("count_held0", count, 0);
      tick(1);
      chk("rej_empty_lo", reject_empty, 0);
      depart_btn = 1'b0;
      tick(2);
      wait_done("wv_c0");
      chk("wait_c0b", wait_time, 0);

      arrive_btn = 1'b1; depart_btn = 1'b1;
      tick(3);
      chk("both_c0_cnt", count, 0);
      chk("both_c0_rej", {reject_full, reject_empty}, 0);
      arrive_btn = 1'b0; depart_btn = 1'b0;
      tick(2);

      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      teller_en = 3'b111;
      tick(3);
      chk("active_3", active_tellers, 3);
      wait_done("wv_t3");
      chk("wait_c2_t3", wait_time, 4);

      teller_en = 3'b000;
      tick(3);
      wait_done("wv_t0");
      chk("no_teller_t0", no_teller, 1);
      chk("wait_t0", wait_time, 0);

      teller_en = 3'b011;
      tick(3);
      wait_done("wv_t2b");
      chk("wait_c2_t2b", wait_time, 5);

      // count 3 starts a division; count 4 lands on its last step edge
      arrive_btn = 1'b1;
      tick(3);
      chk("count_3b", count, 3);
      tick(1);
      chk("wv_calc", wait_valid, 0);
      tick(2);
      arrive_btn = 1'b0;
      tick(1);
      arrive_btn = 1'b1;
      tick(3);
      chk("count_4", count, 4);
      tick(1);
      chk("wv_abort", wait_valid, 0);
      chk("wait_hold", wait_time, 5);
      tick(6);
      chk("wv_restart_early", wait_valid, 0);
      tick(1);
      chk("wv_restart", wait_valid, 1);
      chk("wait_c4_t2", wait_time, 10);
      arrive_btn = 1'b0;
      tick(2);

      press(1'b1, 1'b0);
      tick(2);
      chk("wv_mid", wait_valid, 0);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_valid", wait_valid, 1);
      chk("mid_rst_wait", wait_time, 0);
      chk("mid_rst_no_teller", no_teller, 1);
      tick(2);
      reset = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
